// File: rtl/mem_stage_access.sv
// Memory-stage access unit: EX/MEM -> data-memory handshake -> MEM/WB register.
// Latency: ALU ops 1 cycle; loads/stores 1 request cycle plus memory ack delay.
// Backpressure: stall_out (combinational) holds upstream while an access is pending.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses unacked after TIMEOUT WAIT cycles.
module mem_stage_access #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [4:0]        mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_store_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_out,
  output logic [DATA_W-1:0] wb_result,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic              dmem_err
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // A load wins when both read and write are set, so no write is ever issued for it.
  logic is_mem_op;
  logic is_load;
  logic wb_we_next;
  logic ack_fire;
  logic abort;

  assign is_mem_op  = mem_read | mem_write;
  assign is_load    = mem_read;
  assign wb_we_next = mem_reg_write & (|mem_rd);
  assign ack_fire   = (state_q == WAIT) & dmem_ack;

  // TIMEOUT below 2 would leave no room for a normal ack before the abort cycle.
  if (TIMEOUT < 2) begin : g_timeout_range_check
    $error("mem_stage_access: TIMEOUT must be >= 2");
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  // Abort fires on the TIMEOUT-th WAIT cycle; an ack in that same cycle takes priority.
  assign abort = (state_q == WAIT) & ~dmem_ack & (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Count WAIT cycles without ack; cleared as the unit enters WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state_q == IDLE && is_mem_op) begin
      tmo_cnt <= '0;
    end else if (state_q == WAIT && !dmem_ack && !abort) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Sticky error flag, only cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  assign dmem_err = err_q;
`else
  assign abort    = 1'b0;
  assign dmem_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and the combinational stall back to upstream.
  always_comb begin
    state_d   = state_q;
    stall_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem_op) begin
          stall_out = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (ack_fire || abort) begin
          state_d = IDLE;
        end else begin
          stall_out = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory request registers and the MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wb_result    <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_mem_op) begin
            // Launch the access; the writeback slot becomes a bubble until ack.
            dmem_req     <= 1'b1;
            dmem_we      <= mem_write & ~mem_read;
            dmem_addr    <= mem_alu_result;
            dmem_wdata   <= mem_store_data;
            wb_reg_write <= 1'b0;
          end else begin
            wb_result    <= mem_alu_result;
            wb_rd        <= mem_rd;
            wb_reg_write <= wb_we_next;
          end
        end
        WAIT: begin
          if (ack_fire) begin
            // Upstream has held the op stable, so mem_* still describe it.
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_result    <= is_load ? dmem_rdata : mem_alu_result;
            wb_rd        <= mem_rd;
            wb_reg_write <= wb_we_next;
          end else if (abort) begin
            // The timed-out op is dropped: no register write.
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            wb_reg_write <= 1'b0;
          end else begin
            wb_reg_write <= 1'b0;
          end
        end
        default: begin
          dmem_req     <= 1'b0;
          dmem_we      <= 1'b0;
          wb_reg_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Randomized scoreboard bench for mem_stage_access.
// Stimulus pushes expected requests and writebacks; responder and monitor check them.
// Define MEM_TIMEOUT_EN for both bench and RTL to exercise the abort path (TIMEOUT=4).
module tb_mem_stage_access;

  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] mem_alu_result;
  logic [4:0]    mem_rd;
  logic          mem_reg_write;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_store_data;
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic          stall_out;
  logic [DW-1:0] wb_result;
  logic [4:0]    wb_rd;
  logic          wb_reg_write;
  logic          dmem_err;

  always #5 clk = ~clk;

  mem_stage_access #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .mem_alu_result(mem_alu_result), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_store_data(mem_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_out(stall_out),
    .wb_result(wb_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .dmem_err(dmem_err)
  );

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] result;
  } wb_exp_t;

  typedef struct {
    logic [DW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    int            delay;
    logic [DW-1:0] rdata;
  } req_exp_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];

  int checks   = 0;
  int failures = 0;
  bit resp_en  = 1'b0;
  bit err_exp  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a register write retires exactly one expected writeback.
  always @(negedge clk) begin : wb_monitor
    wb_exp_t e;
    if (!reset && wb_reg_write) begin
      if (wb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected actual rd=%0d result=0x%0h required=no write", wb_rd, wb_result);
      end else begin
        e = wb_q.pop_front();
        check("wb_rd", 64'(wb_rd), 64'(e.rd));
        check("wb_result", 64'(wb_result), 64'(e.result));
      end
    end
  end

  // Memory responder: checks each request, holds it for its delay, then acks.
  // When idle it pulses stray acks, which the unit must ignore.
  initial begin : responder
    req_exp_t cur;
    bit       busy;
    int       cnt;
    busy       = 1'b0;
    cnt        = 0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        if (busy && !dmem_req) busy = 1'b0;  // access aborted by timeout
        if (!busy && dmem_req) begin
          if (req_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL req_unexpected actual addr=0x%0h required=no request", dmem_addr);
          end else begin
            cur  = req_q.pop_front();
            busy = 1'b1;
            cnt  = cur.delay;
            check("req_addr", 64'(dmem_addr), 64'(cur.addr));
            check("req_we", 64'(dmem_we), 64'(cur.we));
            if (cur.we) check("req_wdata", 64'(dmem_wdata), 64'(cur.wdata));
          end
        end else if (busy) begin
          check("req_hold_addr", 64'(dmem_addr), 64'(cur.addr));
          check("req_hold_we", 64'(dmem_we), 64'(cur.we));
        end
        if (busy) begin
          if (cnt == 0) begin
            dmem_ack   = 1'b1;
            dmem_rdata = cur.rdata;
            busy       = 1'b0;
          end else begin
            dmem_ack   = 1'b0;
            dmem_rdata = $urandom;
            cnt--;
          end
        end else begin
          dmem_ack   = ($urandom_range(0, 7) == 0);
          dmem_rdata = $urandom;
        end
      end
    end
  end

  task automatic drive_nop();
    mem_alu_result = '0;
    mem_rd         = '0;
    mem_reg_write  = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_store_data = '0;
  endtask

  // Present one instruction (called just after a rising edge) and hold it while stalled.
  task automatic issue(input logic rd_en, input logic wr_en, input logic rw, input logic [4:0] rd,
                       input logic [DW-1:0] alu, input logic [DW-1:0] sdata,
                       input int delay, input logic [DW-1:0] rdata);
    bit mem_op;
    bit aborted;
    int exp_stall;
    int n;
    req_exp_t r;
    wb_exp_t  w;
    mem_alu_result = alu;
    mem_rd         = rd;
    mem_reg_write  = rw;
    mem_read       = rd_en;
    mem_write      = wr_en;
    mem_store_data = sdata;
    mem_op  = rd_en | wr_en;
    aborted = 1'b0;
`ifdef MEM_TIMEOUT_EN
    aborted = mem_op && (delay >= TMO);
`endif
    if (mem_op) begin
      r.addr = alu; r.we = wr_en & ~rd_en; r.wdata = sdata; r.delay = delay; r.rdata = rdata;
      req_q.push_back(r);
    end
    if (!aborted && rw && rd != 5'd0) begin
      w.rd     = rd;
      w.result = (mem_op && rd_en) ? rdata : alu;
      wb_q.push_back(w);
    end
    exp_stall = !mem_op ? 0 : (aborted ? TMO : delay + 1);
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall_out) break;
      n++;
      if (n > 60) break;
    end
    check("stall_cycles", 64'(n), 64'(exp_stall));
    @(posedge clk);
    #1;
    if (aborted) err_exp = 1'b1;
    check("dmem_err", 64'(dmem_err), 64'(err_exp));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, 64'(dmem_req), 64'd0);
    check({tag, "_we"}, 64'(dmem_we), 64'd0);
    check({tag, "_addr"}, 64'(dmem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(dmem_wdata), 64'd0);
    check({tag, "_wb_result"}, 64'(wb_result), 64'd0);
    check({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
    check({tag, "_wb_reg_write"}, 64'(wb_reg_write), 64'd0);
    check({tag, "_err"}, 64'(dmem_err), 64'd0);
  endtask

  initial begin : stimulus
    bit rd_en, wr_en, rw;
    int kind;
    int max_delay;
    reset = 1'b1;
    drive_nop();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    check("rst_stall", 64'(stall_out), 64'd0);
    reset   = 1'b0;
    resp_en = 1'b1;

    // Directed cases.
    issue(1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, '0, 0, '0);            // ALU op
    issue(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0100, '0, 3, 32'hDEAD_BEEF); // load, 3 extra cycles
    issue(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0200, 32'hA5A5_A5A5, 0, '0); // store
    issue(1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0055, '0, 0, '0);            // rd=0: no write
    issue(1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_0010, '0, 0, 32'h1111_1111); // back-to-back loads
    issue(1'b1, 1'b0, 1'b1, 5'd2, 32'h0000_0013, '0, 0, 32'h2222_2222);
    issue(1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_0301, 32'hFFFF, 1, 32'h1234_5678); // read+write = load
    issue(1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0400, 32'h0BAD_CAFE, 2, '0);       // store with rd
`ifdef MEM_TIMEOUT_EN
    issue(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0500, '0, 100, 32'h3333_3333);       // never acked
    issue(1'b0, 1'b0, 1'b1, 5'd6, 32'h0000_0777, '0, 0, '0);                  // passes normally
    issue(1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0504, '0, TMO - 1, 32'h4444_4444); // ack in abort cycle
    max_delay = TMO + 2;
`else
    max_delay = 5;
`endif

    // Randomized stream.
    for (int i = 0; i < 250; i++) begin
      kind  = $urandom_range(0, 7);
      rd_en = (kind == 4 || kind == 5 || kind == 7);
      wr_en = (kind == 6 || kind == 7);
      rw    = ($urandom_range(0, 3) != 0);
      issue(rd_en, wr_en, rw, 5'($urandom_range(0, 31)), $urandom, $urandom,
            $urandom_range(0, max_delay), $urandom);
    end

    // Reset while waiting on an access, then a late ack.
    drive_nop();
    @(posedge clk);
    resp_en = 1'b0;
    #1;
    dmem_ack = 1'b0;
    mem_read = 1'b1; mem_rd = 5'd3; mem_reg_write = 1'b1; mem_alu_result = 32'h0000_0800;
    @(posedge clk);
    #1;
    check("wait_req", 64'(dmem_req), 64'd1);
    check("wait_stall", 64'(stall_out), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive_nop();
    @(posedge clk);
    #1;
    reset   = 1'b0;
    err_exp = 1'b0;
    check_reset_values("rst_wait");
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h0000_0BAD;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    check("late_ack_req", 64'(dmem_req), 64'd0);
    check("late_ack_wb_reg_write", 64'(wb_reg_write), 64'd0);
    check("late_ack_wb_result", 64'(wb_result), 64'd0);
    resp_en = 1'b1;
    issue(1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_0C0C, '0, 0, '0);
    drive_nop();

    repeat (8) @(posedge clk);
    #1;
    check("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    check("req_queue_drained", 64'(req_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
